// File: rtl/pong_score_keeper.sv
// rtl/pong_score_keeper.sv - Pong score keeper: BCD scores, game-flow FSM and six-digit display codes.
module pong_score_keeper #(
  parameter int WIN_SCORE    = 11,
  parameter int FLASH_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       point_p1,
  input  logic       point_p2,
  output logic [3:0] seg0,
  output logic [3:0] seg1,
  output logic [3:0] seg2,
  output logic [3:0] seg3,
  output logic [3:0] seg4,
  output logic [3:0] seg5,
  output logic       game_over,
  output logic [1:0] winner,
  output logic       serve_en
);

  localparam int              CW       = $clog2(FLASH_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(FLASH_CYCLES - 1);
  localparam logic [7:0]      WIN_BCD  = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};
  localparam logic [3:0]      BLANK    = 4'hF;

  typedef enum logic [1:0] {IDLE, PLAY, WIN} state_t;

  state_t        state, state_n;
  logic [7:0]    p1, p1_n, p2, p2_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          hidden, hidden_n;
  logic [1:0]    win_n;
  logic          hit1, hit2;
  logic [3:0]    seg0_n, seg1_n, seg2_n, seg3_n, seg4_n, seg5_n;
  logic          game_over_n, serve_en_n;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      p1        <= '0;
      p2        <= '0;
      cnt       <= '0;
      hidden    <= 1'b0;
      winner    <= 2'b00;
      seg0      <= 4'd0;
      seg1      <= 4'd0;
      seg2      <= BLANK;
      seg3      <= BLANK;
      seg4      <= 4'd0;
      seg5      <= 4'd0;
      game_over <= 1'b0;
      serve_en  <= 1'b0;
    end else begin
      state     <= state_n;
      p1        <= p1_n;
      p2        <= p2_n;
      cnt       <= cnt_n;
      hidden    <= hidden_n;
      winner    <= win_n;
      seg0      <= seg0_n;
      seg1      <= seg1_n;
      seg2      <= seg2_n;
      seg3      <= seg3_n;
      seg4      <= seg4_n;
      seg5      <= seg5_n;
      game_over <= game_over_n;
      serve_en  <= serve_en_n;
    end
  end

  always_comb begin
    state_n  = state;
    p1_n     = p1;
    p2_n     = p2;
    cnt_n    = cnt;
    hidden_n = hidden;
    win_n    = winner;
    hit1     = 1'b0;
    hit2     = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          p1_n    = '0;
          p2_n    = '0;
          state_n = PLAY;
        end
      end
      PLAY: begin
        if (point_p1) p1_n = bcd_inc(p1);
        if (point_p2) p2_n = bcd_inc(p2);
        hit1 = (p1_n == WIN_BCD);
        hit2 = (p2_n == WIN_BCD);
        if (hit1 || hit2) begin
          state_n  = WIN;
          win_n    = {hit2, hit1};
          cnt_n    = '0;
          hidden_n = 1'b0;
        end
      end
      WIN: begin
        if (start) begin
          p1_n     = '0;
          p2_n     = '0;
          win_n    = 2'b00;
          cnt_n    = '0;
          hidden_n = 1'b0;
          state_n  = PLAY;
        end else if (cnt == CNT_LAST) begin
          cnt_n    = '0;
          hidden_n = ~hidden;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Outputs are derived from next-state values so the display moves on the same edge as the pulse.
    seg5_n = (state_n == WIN && hidden_n && win_n[0]) ? BLANK : p1_n[7:4];
    seg4_n = (state_n == WIN && hidden_n && win_n[0]) ? BLANK : p1_n[3:0];
    seg1_n = (state_n == WIN && hidden_n && win_n[1]) ? BLANK : p2_n[7:4];
    seg0_n = (state_n == WIN && hidden_n && win_n[1]) ? BLANK : p2_n[3:0];
    seg3_n = BLANK;
    if (state_n == WIN) begin
      case (win_n)
        2'b01:   seg3_n = 4'd1;
        2'b10:   seg3_n = 4'd2;
        default: seg3_n = 4'd0;
      endcase
    end
    seg2_n      = BLANK;
    game_over_n = (state_n == WIN);
    serve_en_n  = (state_n == PLAY);
  end

endmodule
